// File: rtl/mul_seq.sv
// Sequential shift-and-add MULT/MULTU unit producing a 2N-bit HI/LO product.
// One ripple-carry adder is reused every iteration; sign is fixed at the end.
module rc_adder #(
  parameter int N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] s_o,
  output logic         c_o
);
  logic [N:0] c;

  always_comb begin
    c   = '0;
    s_o = '0;
    for (int i = 0; i < N; i++) begin
      s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i])
               | (c[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign c_o = c[N];
endmodule

module mul_seq #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         is_signed,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);
  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [N-1:0]  mcand_q, mcand_d;
  logic [N-1:0]  acc_hi_q, acc_hi_d;
  logic [N-1:0]  acc_lo_q, acc_lo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          neg_q, neg_d;
  logic          sgn_q, sgn_d;
  logic [N-1:0]  hi_q, hi_d;
  logic [N-1:0]  lo_q, lo_d;
  logic          done_q, done_d;

  logic [N-1:0]   add_b;
  logic [N-1:0]   sum;
  logic           cout;
  logic [2*N-1:0] prod;
  logic [2*N-1:0] fixed;

  // |x|; the most negative value maps to itself as an unsigned magnitude
  function automatic logic [N-1:0] mag(
    input logic [N-1:0] x
  );
    return x[N-1] ? (~x + 1'b1) : x;
  endfunction

  assign add_b = acc_lo_q[0] ? mcand_q : '0;

  rc_adder #(.N(N)) u_add (
    .a_i (acc_hi_q),
    .b_i (add_b),
    .s_o (sum),
    .c_o (cout)
  );

  assign prod  = {acc_hi_q, acc_lo_q};
  assign fixed = (sgn_q & neg_q) ? (~prod + 1'b1)
                                 : prod;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = ITER;
      ITER: if (cnt_q == LAST) state_d = FIX;
      FIX:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = done_q;
    hi   = hi_q;
    lo   = lo_q;
  end

  always_comb begin
    mcand_d  = mcand_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    sgn_d    = sgn_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sgn_d    = is_signed;
          mcand_d  = is_signed ? mag(a) : a;
          acc_lo_d = is_signed ? mag(b) : b;
          acc_hi_d = '0;
          neg_d    = a[N-1] ^ b[N-1];
          cnt_d    = '0;
        end
      end
      ITER: begin
        {acc_hi_d, acc_lo_d} =
          {cout, sum, acc_lo_q[N-1:1]};
        cnt_d = cnt_q + 1'b1;
      end
      FIX: begin
        {hi_d, lo_d} = fixed;
        done_d       = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      sgn_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      sgn_q    <= sgn_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end
endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq: reset, latency, signed/unsigned
// products, handshake corner cases and a few reference-checked randoms.
module tb_mul_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_pass  = 0;
  int n_total = 0;

  mul_seq #(.N(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_total++;
    if (got !== exp)
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // start edge, then count edges until done (bounded)
  task automatic run(
    input string       tag,
    input logic [31:0] ta,
    input logic [31:0] tb,
    input logic        ts,
    input logic [63:0] exp
  );
    int n;
    start = 1'b1; a = ta; b = tb; is_signed = ts;
    step();
    start = 1'b0;
    a = $urandom; b = $urandom;
    is_signed = ~ts;
    chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
    n = 0;
    while (!done && n < 100) begin
      step();
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'd33);
    chk({tag, "_busy_off"}, {63'd0, busy}, 64'd0);
    chk(tag, {hi, lo}, exp);
    step();
    chk({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    int n, k, dones;
    logic [31:0] ra, rb;
    logic        rs;
    logic [63:0] ea, eb;

    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0;
    a = '0; b = '0;
    step(); step();
    rst_n = 1'b1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);

    // reset at cycle 10 of an operation
    start = 1'b1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    step();
    start = 1'b0;
    for (int i = 0; i < 9; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done) dones++;
    end
    chk("abort_dones", 64'(dones), 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);

    run("umax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0,
        64'hFFFF_FFFE_0000_0001);
    run("u7x6", 32'd7, 32'd6, 1'b0, 64'd42);
    run("sm2x3", 32'hFFFF_FFFE, 32'd3, 1'b1,
        64'hFFFF_FFFF_FFFF_FFFA);
    run("sm1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1,
        64'd1);
    run("sminsq", 32'h8000_0000, 32'h8000_0000, 1'b1,
        64'h4000_0000_0000_0000);
    run("zero", 32'd0, 32'h1234_5678, 1'b0, 64'd0);
    run("uid", 32'd1, 32'hDEAD_BEEF, 1'b0,
        64'h0000_0000_DEAD_BEEF);
    run("sid", 32'd1, 32'hDEAD_BEEF, 1'b1,
        64'hFFFF_FFFF_DEAD_BEEF);

    // re-pulsed start and changed operands mid-operation
    start = 1'b1; a = 32'd7; b = 32'd6; is_signed = 1'b0;
    step();
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 60; i++) begin
      if (i >= 4 && i < 8) begin
        start = 1'b1; a = 32'd100; b = 32'd100;
      end else begin
        start = 1'b0;
      end
      step();
      if (done) dones++;
      if (done && dones == 1)
        chk("repulse_res", {hi, lo}, 64'd42);
    end
    chk("repulse_dones", 64'(dones), 64'd1);

    // start issued in the done cycle
    start = 1'b1; a = 32'd3; b = 32'd5; is_signed = 1'b0;
    step();
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin step(); n++; end
    chk("b2b_first", {hi, lo}, 64'd15);
    start = 1'b1; a = 32'd9; b = 32'd9;
    step();
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      step();
      n++;
      if (n == 32) chk("b2b_hold", {hi, lo}, 64'd15);
    end
    chk("b2b_lat", 64'(n), 64'd33);
    chk("b2b_second", {hi, lo}, 64'd81);

    // start held high: one op every N+2 cycles
    step();
    start = 1'b1; a = 32'd2; b = 32'd3;
    n = 0;
    while (!done && n < 100) begin step(); n++; end
    k = 0;
    step();
    k++;
    while (!done && k < 100) begin step(); k++; end
    start = 1'b0;
    chk("hold_spacing", 64'(k), 64'd34);
    chk("hold_res", {hi, lo}, 64'd6);
    for (int i = 0; i < 3; i++) step();

    for (int i = 0; i < 16; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom);
      ea = rs ? {{32{ra[31]}}, ra} : {32'd0, ra};
      eb = rs ? {{32{rb[31]}}, rb} : {32'd0, rb};
      k = $urandom_range(0, 3);
      for (int j = 0; j < k; j++) step();
      run($sformatf("rnd%0d", i), ra, rb, rs, ea * eb);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
